// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch/PC stage with an imem req/ready handshake, next-PC selection and a fetch timeout.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        pcsrc,
    input  logic [1:0]  jump,
    input  logic [31:0] rs_data,
    output logic [31:0] instr,
    output logic [5:0]  operation,
    output logic [5:0]  functions_number,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, HALT} state_t;
    state_t state, next_state;
    logic [7:0]  count;
    logic [31:0] next_pc;
    logic [31:0] br_off;
    logic        timed_out;
    assign imem_req         = state == FETCH;
    assign imem_addr        = pc;
    assign instr_valid      = state == EXEC;
    assign operation        = instr[31:26];
    assign functions_number = instr[5:0];
    assign pc_plus4         = pc + 32'd4;
    assign br_off           = {{14{instr[15]}}, instr[15:0], 2'b00};
    assign timed_out        = count == 8'(TIMEOUT - 1);
    always_comb begin
        next_pc = pc_plus4;
        if (jump == 2'b01)
            next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
        else if (jump == 2'b10)
            next_pc = {rs_data[31:2], 2'b00};
        else if (jump == 2'b00 && pcsrc)
            next_pc = pc_plus4 + br_off;
    end
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  next_state = stall ? IDLE : FETCH;
            FETCH: next_state = imem_ready ? EXEC : (timed_out ? HALT : FETCH);
            EXEC:  next_state = stall ? IDLE : FETCH;
            HALT:  next_state = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= next_state;
    end
    // pc and instr only change on handshake/commit edges, so imem_addr is stable during FETCH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc        <= RESET_PC;
            instr     <= '0;
            count     <= '0;
            fetch_err <= 1'b0;
        end else begin
            if (state == FETCH) begin
                if (imem_ready) begin
                    instr <= imem_rdata;
                    count <= '0;
                end else begin
                    count <= count + 8'd1;
                    if (timed_out)
                        fetch_err <= 1'b1;
                end
            end
            if (state == EXEC)
                pc <= next_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_fetch_unit;
    logic        clk = 0, reset_n = 0, imem_ready = 0, stall = 0, pcsrc = 0;
    logic [31:0] imem_rdata = 0, rs_data = 0;
    logic [1:0]  jump = 0;
    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [5:0]  operation, functions_number;
    int checks = 0, errors = 0;
    time t_acc, t1, t2;

    typedef struct {logic [31:0] ins; logic [31:0] pc;} exec_t;
    logic [31:0] addr_q[$];
    exec_t       exec_q[$];

    fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready), .stall(stall), .pcsrc(pcsrc),
        .jump(jump), .rs_data(rs_data), .instr(instr), .operation(operation),
        .functions_number(functions_number), .instr_valid(instr_valid), .pc(pc),
        .pc_plus4(pc_plus4), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not expected or not seen", name);
    endtask

    always @(negedge clk) begin : monitor
        exec_t e;
        if (reset_n) begin
            if (imem_req) begin
                if (addr_q.size() == 0) fail("unexpected_req");
                else begin
                    chk("imem_addr", imem_addr, addr_q[0]);
                    if (imem_ready) void'(addr_q.pop_front());
                end
            end
            if (instr_valid) begin
                if (exec_q.size() == 0) fail("unexpected_exec");
                else begin
                    e = exec_q.pop_front();
                    chk("instr", instr, e.ins);
                    chk("operation", 32'(operation), 32'(e.ins[31:26]));
                    chk("functions_number", 32'(functions_number), 32'(e.ins[5:0]));
                    chk("pc", pc, e.pc);
                    chk("pc_plus4", pc_plus4, e.pc + 32'd4);
                    chk("req_in_exec", 32'(imem_req), 32'd0);
                end
            end
        end
    end

    task automatic fetch_one(input logic [31:0] addr, input logic [31:0] ins, input int waits,
                             input logic ps, input logic [1:0] jp, input logic [31:0] rs, input logic st);
        int n = 0;
        addr_q.push_back(addr);
        exec_q.push_back(exec_t'{ins, addr});
        while (!imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!imem_req) begin
            fail("req_wait");
            return;
        end
        repeat (waits) begin
            @(posedge clk); #1;
        end
        imem_ready = 1; imem_rdata = ins; pcsrc = ps; jump = jp; rs_data = rs; stall = st;
        t_acc = $time;
        @(posedge clk); #1;
        imem_ready = 0; imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        pcsrc = 0; jump = 0; rs_data = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        #1;
        chk("rst_req", 32'(imem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_err", 32'(fetch_err), 0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        chk("idle_req", 32'(imem_req), 0);
        @(posedge clk); #1;
        fetch_one(32'h0, 32'h2008_0005, 0, 0, 2'b00, 0, 0);
        t1 = t_acc;
        fetch_one(32'h4, 32'h2008_0005, 0, 0, 2'b10, 32'h13, 0);
        t2 = t_acc;
        chk("rate_2_cycles", 32'(t2 - t1), 32'd20);
        fetch_one(32'h10, 32'h1000_FFFE, 0, 1, 2'b00, 0, 0);
        fetch_one(32'h0C, 32'h0000_0008, 0, 0, 2'b10, 32'h10, 0);
        fetch_one(32'h10, 32'h1000_FFFE, 0, 0, 2'b00, 0, 0);
        fetch_one(32'h14, 32'h0000_0008, 0, 0, 2'b10, 32'h4000_0000, 0);
        fetch_one(32'h4000_0000, 32'h0800_0100, 0, 1, 2'b01, 0, 0);
        fetch_one(32'h4000_0400, 32'h0000_0008, 0, 0, 2'b10, 32'h203, 0);
        fetch_one(32'h200, 32'h0000_0008, 3, 0, 2'b10, 32'hFFFF_FFFC, 0);
        fetch_one(32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 2'b11, 0, 0);
        fetch_one(32'h0, 32'h2008_0005, 0, 0, 2'b00, 0, 1);
        repeat (3) begin
            chk("stall_idle_req", 32'(imem_req), 0);
            @(posedge clk); #1;
        end
        stall = 0;
        fetch_one(32'h4, 32'h8C09_0004, 0, 0, 2'b00, 0, 0);
        addr_q.push_back(32'h8);
        chk("mid_fetch_req", 32'(imem_req), 1);
        #2 reset_n = 0;
        addr_q.delete();
        #1;
        chk("async_rst_req", 32'(imem_req), 0);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_instr", instr, 32'h0);
        chk("async_rst_valid", 32'(instr_valid), 0);
        @(posedge clk); #1 reset_n = 1;
        @(posedge clk); #1;
        fetch_one(32'h0, 32'h2008_0005, 0, 0, 2'b00, 0, 0);
        addr_q.push_back(32'h4);
        n = 0;
        while (imem_req && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd16);
        chk("timeout_err", 32'(fetch_err), 1);
        repeat (5) begin
            @(posedge clk); #1;
            chk("halt_req", 32'(imem_req), 0);
            chk("halt_pc", pc, 32'h4);
        end
        addr_q.delete();
        if (exec_q.size() != 0) fail("exec_pending");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch and PC stage of the single-cycle core. It sits directly upstream of the main/ALU decode controller.
- Fetches a word from instruction memory over a req/ready handshake and holds it in an instruction register.
- Drives the opcode and function fields into the controller.
- Consumes the controller's pcsrc and jump outputs to compute and commit the next PC.
- A timeout counter halts the core if instruction memory never answers.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max cycles imem_req may stay unanswered before a fetch error; legal range 1..255.

Ports:
- clk  in  1  core clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request, held until accepted.
- imem_addr  out  32  fetch address (= pc), stable while imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_ready=1.
- imem_ready  in  1  memory accepts/returns data this cycle.
- stall  in  1  inhibits starting a new fetch.
- pcsrc  in  1  branch taken (controller).
- jump  in  2  00 seq/branch, 01 j/jal, 10 jr, 11 reserved.
- rs_data  in  32  register-file rs value, jr target.
- instr  out  32  instruction register.
- operation  out  6  instr[31:26].
- functions_number  out  6  instr[5:0].
- instr_valid  out  1  EXEC-cycle strobe; downstream gates regwrite/memwrite with it.
- pc  out  32  address of the instruction in instr.
- pc_plus4  out  32  pc+4, the jal link value.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, reset_n=0) values:
  - pc=RESET_PC, instr=0, state=IDLE, timeout count=0.
  - imem_req=0, instr_valid=0, fetch_err=0.
- Reset asserted mid-fetch aborts immediately; no partial instruction is retained.
- State machine states: IDLE, FETCH, EXEC, HALT.
- IDLE:
  - All strobes low.
  - If stall=0, go to FETCH next cycle; else remain in IDLE.
- FETCH:
  - imem_req=1, imem_addr=pc; the count increments each cycle.
  - If imem_ready=1: instr<=imem_rdata, count<=0, go to EXEC.
  - Else if count==TIMEOUT-1: fetch_err<=1, go to HALT.
  - Minimum fetch latency: 1 cycle with ready high → instr visible in the next cycle.
  - stall is ignored once in FETCH; a started request is never withdrawn.
- EXEC:
  - instr_valid=1 for exactly one cycle, imem_req=0.
  - operation/functions_number reflect instr combinationally.
  - The controller resolves pcsrc/jump in the same cycle.
  - At the clock edge, pc<=next_pc and the state goes to FETCH if stall=0, else IDLE.
- next_pc priority:
  - jump==01 → {pc_plus4[31:28], instr[25:0], 2'b00}.
  - jump==10 → rs_data.
  - jump==00 & pcsrc → pc_plus4 + {sext(instr[15:0]), 2'b00}.
  - Otherwise (including jump==11) → pc_plus4.
- Arithmetic: all additions mod 2^32 and wrap silently (pc=FFFF_FFFC → pc_plus4=0).
- pc and instr are stable throughout FETCH; both are outputs of flops, not of muxes fed from imem.
- HALT:
  - Terminal; all strobes low; pc frozen; fetch_err=1.
  - Only reset exits HALT.
- Misaligned jr target: bits [1:0] are forced to 00 before loading pc.

Test Plan:
- Reset, stall=0, imem_ready=1 always, imem_rdata=32'h2008_0005 → IDLE, FETCH addr 0, EXEC with operation=6'h08 and instr_valid one cycle; next fetch addr 4; steady rate 1 instruction per 2 cycles.
- Branch: pc=0x10, instr imm=16'hFFFE, pcsrc=1, jump=00 → next imem_addr=0x0C; same with pcsrc=0 → 0x14.
- Jump/jr: pc=0x4000_0000, instr[25:0]=26'h0000100, jump=01 → addr 0x4000_0400. jump=10, rs_data=0x0000_0203 → addr 0x0000_0200. jump=01 together with pcsrc=1 → jump wins.
- Wait states and timeout:
  - imem_ready low 3 cycles, then high → imem_req and addr held stable 4 cycles, instr captured once.
  - imem_ready never high, TIMEOUT=16 → fetch_err=1 after 16 FETCH cycles, HALT, imem_req=0 forever.
- Stall and reset:
  - stall=1 during EXEC → IDLE with no req until stall=0.
  - reset_n pulsed low mid-FETCH → outputs return to reset values asynchronously, refetch from RESET_PC.
- Wrap: pc=0xFFFF_FFFC, jump=00, pcsrc=0 → pc_plus4=0, next fetch addr 0x0000_0000.
